// File: rtl/sequenced_tap_mux.sv
// Registered N-input tap selector with direct indexed select and internal sweep.
// Optional zero-tap skipping during sweeps: define SEQ_TAP_ZERO_SKIP_EN.
module sequenced_tap_mux #(
    parameter int NUM_IN     = 7,
    parameter int DATA_WIDTH = 16,
    parameter int SEL_W      = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   in_bus,
    input  logic                           mode,
    input  logic [SEL_W-1:0]               sel,
    input  logic                           sel_valid,
    output logic                           sel_ready,
    input  logic                           start,
    input  logic [SEL_W-1:0]               last_idx,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]               out_idx,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           sel_err
);

    // state   | meaning
    // S_IDLE  | accepting direct requests or a sweep launch
    // S_SWEEP | stepping the counter through taps 0..lim

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    localparam logic [SEL_W:0]   NUM_IN_X = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] MAX_IDX  = SEL_W'(NUM_IN-1);

    function automatic logic [DATA_WIDTH-1:0] tap_at(
        input logic [SEL_W-1:0]             idx,
        input logic [NUM_IN*DATA_WIDTH-1:0] bus
    );
        tap_at = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (idx == SEL_W'(k)) tap_at = bus[k*DATA_WIDTH +: DATA_WIDTH];
        end
    endfunction

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]      lim_q, lim_d;
    logic                  iss_q, iss_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]      out_idx_q, out_idx_d;
    logic                  out_last_q, out_last_d;
    logic                  out_valid_q, out_valid_d;
    logic                  done_q, done_d;
    logic                  sel_err_q, sel_err_d;
`ifdef SEQ_TAP_ZERO_SKIP_EN
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic [SEL_W-1:0]      pend_idx_q, pend_idx_d;
    logic                  any_q, any_d;
`endif

    logic                  busy_q;
    logic                  free;
    logic                  sel_oor;
    logic                  last_hs;
    logic [DATA_WIDTH-1:0] tap_cur;

    assign busy_q    = (state_q == S_SWEEP);
    assign free      = !out_valid_q || out_ready;
    assign sel_ready = !busy_q && free;
    assign sel_oor   = ({1'b0, sel} >= NUM_IN_X);
    assign last_hs   = out_valid_q && out_ready && out_last_q && busy_q;
    assign tap_cur   = tap_at(cnt_q, in_bus);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lim_d       = lim_q;
        iss_d       = iss_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q;
        done_d      = 1'b0;
`ifdef SEQ_TAP_ZERO_SKIP_EN
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        pend_idx_d  = pend_idx_q;
        any_d       = any_q;
`endif

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sel_ready) begin
                    if (!mode && sel_valid) begin
                        out_data_d  = sel_oor ? '0 : tap_at(sel, in_bus);
                        out_idx_d   = sel;
                        out_last_d  = 1'b1;
                        out_valid_d = 1'b1;
                        sel_err_d   = sel_oor;
                    end else if (mode && start) begin
                        lim_d   = ({1'b0, last_idx} >= NUM_IN_X) ? MAX_IDX : last_idx;
                        cnt_d   = '0;
                        iss_d   = 1'b1;
                        state_d = S_SWEEP;
`ifdef SEQ_TAP_ZERO_SKIP_EN
                        pend_d  = 1'b0;
                        any_d   = 1'b0;
`endif
                    end
                end
            end

            S_SWEEP: begin
`ifdef SEQ_TAP_ZERO_SKIP_EN
                // A nonzero tap waits in the pending slot until the next nonzero
                // tap (or the end of the scan) decides whether it is the last beat.
                if (iss_q) begin
                    if (tap_cur == '0 || !pend_q || free) begin
                        if (tap_cur != '0) begin
                            if (pend_q) begin
                                out_data_d  = pend_data_q;
                                out_idx_d   = pend_idx_q;
                                out_last_d  = 1'b0;
                                out_valid_d = 1'b1;
                                sel_err_d   = 1'b0;
                            end
                            pend_d      = 1'b1;
                            pend_data_d = tap_cur;
                            pend_idx_d  = cnt_q;
                            any_d       = 1'b1;
                        end
                        if (cnt_q == lim_q) iss_d = 1'b0;
                        else                cnt_d = cnt_q + SEL_W'(1);
                    end
                end else if (pend_q) begin
                    if (free) begin
                        out_data_d  = pend_data_q;
                        out_idx_d   = pend_idx_q;
                        out_last_d  = 1'b1;
                        out_valid_d = 1'b1;
                        sel_err_d   = 1'b0;
                        pend_d      = 1'b0;
                    end
                end else if (!any_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
`else
                if (iss_q && free) begin
                    out_data_d  = tap_cur;
                    out_idx_d   = cnt_q;
                    out_last_d  = (cnt_q == lim_q);
                    out_valid_d = 1'b1;
                    sel_err_d   = 1'b0;
                    if (cnt_q == lim_q) iss_d = 1'b0;
                    else                cnt_d = cnt_q + SEL_W'(1);
                end
`endif
                if (last_hs) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lim_q       <= '0;
            iss_q       <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            sel_err_q   <= 1'b0;
`ifdef SEQ_TAP_ZERO_SKIP_EN
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            pend_idx_q  <= '0;
            any_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lim_q       <= lim_d;
            iss_q       <= iss_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            sel_err_q   <= sel_err_d;
`ifdef SEQ_TAP_ZERO_SKIP_EN
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            pend_idx_q  <= pend_idx_d;
            any_q       <= any_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_sequenced_tap_mux.sv
// Bench for sequenced_tap_mux (default build): directed literal checks plus a
// queue-based beat model compared against the DUT every cycle under random stimulus.
module tb_sequenced_tap_mux;

    localparam int N  = 7;
    localparam int DW = 16;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] in_bus;
    logic            mode;
    logic [SW-1:0]   sel;
    logic            sel_valid;
    logic            sel_ready;
    logic            start;
    logic [SW-1:0]   last_idx;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_idx;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            done;
    logic            sel_err;

    always #5 clk = ~clk;

    sequenced_tap_mux #(.NUM_IN(N), .DATA_WIDTH(DW), .SEL_W(SW)) dut (
        .clk(clk), .rst(rst), .in_bus(in_bus), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .sel_ready(sel_ready), .start(start),
        .last_idx(last_idx), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .sel_err(sel_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: current output beat plus a queue of tap indices still owed by a sweep.
    logic          m_valid = 0, m_last = 0, m_err = 0, m_busy = 0, m_done = 0;
    logic [DW-1:0] m_data = 0;
    logic [SW-1:0] m_idx = 0;
    int            m_q[$];
    bit            started = 0;

    function automatic logic [DW-1:0] tap(input int k);
        return (k < N) ? in_bus[k*DW +: DW] : '0;
    endfunction

    always @(posedge clk) begin : model
        bit free, hs, b;
        int lim, k;
        free = !m_valid || out_ready;
        b    = m_busy;
        if (rst) begin
            m_valid = 0; m_last = 0; m_err = 0; m_busy = 0; m_done = 0;
            m_data = 0; m_idx = 0;
            m_q.delete();
        end else begin
            hs = m_valid && out_ready;
            m_done = 0;
            if (hs) m_valid = 0;
            if (hs && m_last && b) begin
                m_busy = 0;
                m_done = 1;
            end
            if (!b && free) begin
                if (!mode && sel_valid) begin
                    m_valid = 1; m_idx = sel; m_last = 1;
                    m_err = (int'(sel) >= N);
                    m_data = tap(int'(sel));
                end else if (mode && start) begin
                    lim = (int'(last_idx) > N-1) ? N-1 : int'(last_idx);
                    m_q.delete();
                    for (int i = 0; i <= lim; i++) m_q.push_back(i);
                    m_busy = 1;
                end
            end else if (b && free && m_q.size() > 0) begin
                k = m_q.pop_front();
                m_valid = 1; m_idx = SW'(k); m_data = tap(k); m_err = 0;
                m_last = (m_q.size() == 0);
            end
        end
        started = 1;
    end

    typedef struct { int idx; int data; bit last; } beat_t;
    beat_t seen[$];
    int    done_cnt = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", out_valid, m_valid);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("sel_ready", sel_ready, !m_busy && (!m_valid || out_ready));
            if (m_valid) begin
                chk("out_data", out_data, m_data);
                chk("out_idx", out_idx, m_idx);
                chk("out_last", out_last, m_last);
                chk("sel_err", sel_err, m_err);
            end
            if (out_valid && out_ready) seen.push_back('{int'(out_idx), int'(out_data), out_last});
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_seen(input string nm, input int n);
        chk({nm, "_count"}, seen.size(), n);
        for (int k = 0; k < n && k < seen.size(); k++) begin
            chk({nm, "_idx"}, seen[k].idx, k);
            chk({nm, "_data"}, seen[k].data, 32'h1000 + k);
            chk({nm, "_last"}, seen[k].last, (k == n-1));
        end
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 60 && !done; i++) tick();
        chk({nm, "_done"}, done, 1);
        chk({nm, "_busy_low"}, busy, 0);
    endtask

    task automatic launch(input logic [SW-1:0] li);
        seen.delete();
        mode = 1; start = 1; last_idx = li;
        tick();
        start = 0;
    endtask

    initial begin
        rst = 1; mode = 0; sel = 0; sel_valid = 0; start = 0; last_idx = 0; out_ready = 1;
        for (int k = 0; k < N; k++) in_bus[k*DW +: DW] = DW'(16'h1000 + k);
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", sel_err, 0);
        rst = 0;

        // direct selects, including an out-of-range index
        mode = 0; sel = 5; sel_valid = 1;
        tick();
        chk("dir5_data", out_data, 16'h1005);
        chk("dir5_idx", out_idx, 5);
        chk("dir5_last", out_last, 1);
        chk("dir5_err", sel_err, 0);
        sel = 7;
        tick();
        chk("dir7_data", out_data, 0);
        chk("dir7_idx", out_idx, 7);
        chk("dir7_err", sel_err, 1);
        sel = 2;
        tick();
        chk("dir2_data", out_data, 16'h1002);
        chk("dir2_err", sel_err, 0);
        sel_valid = 0;
        tick();

        launch(6);
        wait_done("full");
        check_seen("full", 7);
        tick();
        chk("done_pulse", done, 0);

        // backpressure at idx 1
        launch(3);
        for (int i = 0; i < 20 && !(out_valid && out_idx == 1); i++) tick();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_idx", out_idx, 1);
            chk("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1;
        wait_done("bp");
        check_seen("bp", 4);

        launch(7);
        wait_done("clamp");
        check_seen("clamp", 7);

        // reset mid-sweep
        launch(6);
        for (int i = 0; i < 20 && !(out_valid && out_idx == 3); i++) tick();
        chk("mid_idx3", out_idx, 3);
        rst = 1;
        tick();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_idx", out_idx, 0);
        chk("midrst_busy", busy, 0);
        rst = 0;
        tick();

        // direct request during a sweep is ignored
        launch(6);
        mode = 0; sel = 2; sel_valid = 1;
        for (int i = 0; i < 60 && !done; i++) begin
            chk("busy_sel_ready", sel_ready, 0);
            tick();
        end
        chk("ign_done", done, 1);
        check_seen("ign", 7);
        sel_valid = 0;
        tick(); tick();

        // randomized phase
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            mode      = $urandom_range(0, 1);
            sel       = SW'($urandom_range(0, 7));
            sel_valid = $urandom_range(0, 1);
            start     = ($urandom_range(0, 3) == 0);
            last_idx  = SW'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++)
                in_bus[k*DW +: DW] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            tick();
        end
        rst = 0; sel_valid = 0; start = 0; out_ready = 1;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
